// File: rtl/mm2s_axis_out.sv
// MM2S output stage: drains a FWFT data FIFO into an AXI4-Stream master.
// One command = one packet of i_cmd_len beats, TLAST on the final beat.
module mm2s_axis_out #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_cmd_valid,
  input  logic [LEN_W-1:0]      i_cmd_len,
  output logic                  o_cmd_ready,
  input  logic [DATA_WIDTH-1:0] i_fifo_data,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_rd,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             out_free;
  logic             pop;
  logic             hs;
  logic             last_hs;

  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign pop = (state == RUN) && !i_fifo_empty &&
               (remaining != '0) && out_free;
  assign hs = m_axis_tvalid && m_axis_tready;
  assign last_hs = hs && m_axis_tlast;

  // reset gate keeps the FIFO untouched while the block is being reset
  assign o_fifo_rd   = pop && !reset;
  assign o_cmd_ready = (state == IDLE);
  assign o_busy      = (state == RUN);

  // command FSM, beat counter and registered stream outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_cmd_valid && (i_cmd_len != '0)) begin
            remaining <= i_cmd_len;
            state     <= RUN;
          end
        end
        RUN: begin
          if (pop)
            remaining <= remaining - LEN_W'(1);
          if (last_hs) begin
            state  <= IDLE;
            o_done <= 1'b1;
          end
        end
      endcase
      if (pop) begin
        m_axis_tdata  <= i_fifo_data;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= (remaining == LEN_W'(1));
      end else if (hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mm2s_axis_out.sv
// Directed bench for mm2s_axis_out with a queue-based FWFT FIFO model.
// Checks are immediate assertions; summary line at the end.
module tb_mm2s_axis_out;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_cmd_valid = 1'b0;
  logic [LW-1:0] i_cmd_len = '0;
  logic          o_cmd_ready;
  logic [DW-1:0] i_fifo_data = '0;
  logic          i_fifo_empty = 1'b1;
  logic          o_fifo_rd;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          o_busy;
  logic          o_done;

  mm2s_axis_out #(
    .DATA_WIDTH(DW),
    .LEN_W(LW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_cmd_valid(i_cmd_valid),
    .i_cmd_len(i_cmd_len),
    .o_cmd_ready(o_cmd_ready),
    .i_fifo_data(i_fifo_data),
    .i_fifo_empty(i_fifo_empty),
    .o_fifo_rd(o_fifo_rd),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW:0]   beats[$];
  int            n_done = 0;
  int            checks = 0;
  int            fails = 0;
  bit            acc;

  task automatic upd();
    i_fifo_empty = (q.size() == 0);
    i_fifo_data = (q.size() != 0) ? q[0] : '0;
  endtask

  task automatic cyc();
    bit pop;
    @(negedge clk);
    pop = o_fifo_rd;
    acc = i_cmd_valid && o_cmd_ready;
    if (!reset && m_axis_tvalid && m_axis_tready)
      beats.push_back({m_axis_tlast, m_axis_tdata});
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    upd();
    if (o_done) n_done++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [LW-1:0] len);
    i_cmd_valid = 1'b1;
    i_cmd_len = len;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cyc();
    i_cmd_valid = 1'b0;
    chk("cmd_accept", acc, 1);
  endtask

  task automatic run_idle(input int budget);
    for (int i = 0; i < budget && o_busy; i++) cyc();
    chk("back_to_idle", o_busy, 0);
  endtask

  initial begin
    int k;
    int nlast;
    int derr;
    upd();
    cyc();
    cyc();
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fifo_rd", o_fifo_rd, 0);
    reset = 1'b0;
    cyc();
    chk("rst_cmd_ready", o_cmd_ready, 1);

    // len 4, A0..A3 preloaded, sink always ready
    for (int i = 0; i < 4; i++) q.push_back(32'hA000_0000 + i);
    upd();
    n_done = 0;
    send_cmd(16'd4);
    chk("t1_busy", o_busy, 1);
    chk("t1_cmd_ready", o_cmd_ready, 0);
    chk("t1_tvalid0", m_axis_tvalid, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t1_tvalid", m_axis_tvalid, 1);
      chk("t1_tdata", m_axis_tdata, 32'hA000_0000 + i);
      chk("t1_tlast", m_axis_tlast, (i == 3) ? 1 : 0);
    end
    cyc();
    chk("t1_done", o_done, 1);
    chk("t1_cmd_ready_after", o_cmd_ready, 1);
    chk("t1_tvalid_after", m_axis_tvalid, 0);
    chk("t1_tlast_after", m_axis_tlast, 0);
    cyc();
    chk("t1_done_pulse", o_done, 0);
    chk("t1_done_count", n_done, 1);

    // len 3 with backpressure on the first beat
    for (int i = 0; i < 3; i++) q.push_back(32'hB000_0000 + i);
    upd();
    send_cmd(16'd3);
    cyc();
    chk("t2_b0", m_axis_tdata, 32'hB000_0000);
    chk("t2_b0_valid", m_axis_tvalid, 1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t2_hold_data", m_axis_tdata, 32'hB000_0000);
      chk("t2_hold_valid", m_axis_tvalid, 1);
      chk("t2_hold_last", m_axis_tlast, 0);
      chk("t2_fifo_count", q.size(), 2);
    end
    m_axis_tready = 1'b1;
    cyc();
    chk("t2_b1", m_axis_tdata, 32'hB000_0001);
    chk("t2_b1_last", m_axis_tlast, 0);
    cyc();
    chk("t2_b2", m_axis_tdata, 32'hB000_0002);
    chk("t2_b2_last", m_axis_tlast, 1);
    cyc();
    chk("t2_done", o_done, 1);

    // len 5, FIFO trickle-fed, extra words must stay
    beats.delete();
    n_done = 0;
    send_cmd(16'd5);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      if ((i % 3) == 0 && k < 5) begin
        q.push_back(32'hD000_0000 + k);
        k++;
        if (k == 5) begin
          q.push_back(32'hE000_0000);
          q.push_back(32'hE000_0001);
        end
        upd();
      end
      cyc();
    end
    chk("t3_beats", beats.size(), 5);
    for (int i = 0; i < 5 && i < beats.size(); i++)
      chk("t3_beat", beats[i], {(i == 4), 32'hD000_0000 + i});
    chk("t3_fifo_left", q.size(), 2);
    chk("t3_done_count", n_done, 1);
    chk("t3_idle", o_busy, 0);
    q.delete();
    upd();

    // len 1 then len 2, then a zero-length command
    for (int i = 0; i < 3; i++) q.push_back(32'hC000_0000 + i);
    upd();
    beats.delete();
    n_done = 0;
    send_cmd(16'd1);
    run_idle(20);
    send_cmd(16'd2);
    run_idle(20);
    chk("t4_beats", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("t4_c0", beats[0], {1'b1, 32'hC000_0000});
      chk("t4_c1", beats[1], {1'b0, 32'hC000_0001});
      chk("t4_c2", beats[2], {1'b1, 32'hC000_0002});
    end
    chk("t4_done_count", n_done, 2);
    q.push_back(32'hF000_0000);
    upd();
    beats.delete();
    n_done = 0;
    send_cmd(16'd0);
    chk("t4_len0_busy", o_busy, 0);
    repeat (3) cyc();
    chk("t4_len0_beats", beats.size(), 0);
    chk("t4_len0_done", n_done, 0);
    chk("t4_len0_fifo", q.size(), 1);
    q.delete();
    upd();

    // reset in the middle of a 6-beat packet
    for (int i = 0; i < 6; i++) q.push_back(32'h6000_0000 + i);
    upd();
    beats.delete();
    send_cmd(16'd6);
    for (int i = 0; i < 20 && beats.size() < 2; i++) cyc();
    chk("t5_two_beats", beats.size(), 2);
    reset = 1'b1;
    cyc();
    chk("t5_tvalid", m_axis_tvalid, 0);
    chk("t5_tlast", m_axis_tlast, 0);
    chk("t5_busy", o_busy, 0);
    chk("t5_cmd_ready", o_cmd_ready, 1);
    chk("t5_done", o_done, 0);
    chk("t5_fifo_rd", o_fifo_rd, 0);
    nlast = 0;
    foreach (beats[i]) if (beats[i][DW]) nlast++;
    chk("t5_no_tlast", nlast, 0);
    reset = 1'b0;
    q.delete();
    upd();
    cyc();

    // maximum length packet
    for (int i = 0; i < 65536; i++) q.push_back(i);
    upd();
    beats.delete();
    n_done = 0;
    send_cmd(16'hFFFF);
    run_idle(70000);
    cyc();
    chk("t6_beats", beats.size(), 65535);
    nlast = 0;
    derr = 0;
    foreach (beats[i]) begin
      if (beats[i][DW]) nlast++;
      if (beats[i][DW-1:0] !== i) derr++;
    end
    chk("t6_tlast_count", nlast, 1);
    if (beats.size() == 65535)
      chk("t6_final_last", beats[65534][DW], 1);
    chk("t6_data_errors", derr, 0);
    chk("t6_fifo_left", q.size(), 1);
    chk("t6_remaining", dut.remaining, 0);
    chk("t6_done_count", n_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/mm2s_axis_out.md
Name: mm2s_axis_out

Overview:
- Downstream output stage of the MM2S datapath. It drains the first-word-fall-through data FIFO and emits AXI4-Stream beats.
- Each accepted command gives a packet length in beats. The block sends exactly that many beats and asserts TLAST on the final beat.
- The output is fully registered (tdata/tvalid/tlast) and sustains 1 beat/cycle while the FIFO has data and the sink is ready.

Parameters:
- DATA_WIDTH, 32, beat width; must equal the FIFO width.
- LEN_W, 16, width of the packet-length field (beats); maximum packet is 2^LEN_W-1 beats.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- i_cmd_valid  input  1  command valid.
- i_cmd_len  input  LEN_W  packet length in beats; 0 is illegal.
- o_cmd_ready  output  1  block can accept a command.
- i_fifo_data  input  DATA_WIDTH  FIFO head word, valid combinationally when !i_fifo_empty.
- i_fifo_empty  input  1  FIFO empty.
- o_fifo_rd  output  1  pop FIFO head this cycle (combinational).
- m_axis_tdata  output  DATA_WIDTH  stream data (registered).
- m_axis_tvalid  output  1  stream valid (registered).
- m_axis_tlast  output  1  last beat of packet (registered).
- m_axis_tready  input  1  sink ready.
- o_busy  output  1  packet in progress (state != IDLE).
- o_done  output  1  one-cycle pulse after the TLAST handshake.

Behaviour:
- Reset: state=IDLE, remaining=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, o_done=0, o_busy=0. o_fifo_rd=0 while reset is high. o_cmd_ready=1 from the first cycle after reset.
- Reset mid-packet abandons the packet immediately. tvalid drops the next cycle with no TLAST. Unsent FIFO words stay in the FIFO; flushing them is the FIFO reset's job.
- States are IDLE and RUN. o_cmd_ready = (state==IDLE).
- IDLE:
  - i_cmd_valid && i_cmd_len!=0: remaining<=i_cmd_len, go to RUN.
  - i_cmd_valid && i_cmd_len==0: command is consumed, no beats, no o_done, stay in IDLE.
- Output slot free: out_free = !m_axis_tvalid || m_axis_tready.
- Pop: o_fifo_rd = (state==RUN) && !i_fifo_empty && remaining!=0 && out_free.
- On pop:
  - tdata<=i_fifo_data, tvalid<=1, tlast<=(remaining==1).
  - remaining<=remaining-1.
  - remaining never wraps: no pop when it is 0.
- If tvalid && tready with no pop: tvalid<=0, tlast<=0.
- Under backpressure (tvalid && !tready), tdata/tvalid/tlast hold stable, per AXIS rules.
- Latency: FIFO word to tvalid is 1 cycle. Back-to-back beats run with no bubbles.
- RUN to IDLE transition happens on the cycle of the TLAST handshake (tvalid && tready && tlast).
  - o_done=1 for exactly the next cycle.
  - o_cmd_ready is 1 in that same next cycle.
- Between packets there is at least one idle output cycle, from the command-accept cycle.
- FIFO empty in RUN: no pop; tvalid falls after the pending beat handshakes. Streaming resumes the cycle after data appears.
- The FIFO is never popped in IDLE. Words for a future packet wait in the FIFO.
- Invariant: beats handshaked per packet == i_cmd_len.
- Invariant: tlast is asserted only with tvalid, and exactly once per packet.

Test Plan:
- Cmd len=4, FIFO preloaded A0..A3, tready=1 -> tvalid cycles 1..4 after cmd accept+1. Data A0,A1,A2,A3, tlast only on A3, o_done pulses one cycle later, o_cmd_ready=1 again.
- Len=3, FIFO holds B0..B2, tready low for 3 cycles after first tvalid -> B0 held stable, no extra pops (FIFO count stays 2). Then B1, B2 with tlast on B2.
- Len=5, FIFO fed one word every 3 cycles -> tvalid gaps while empty, 5 beats total, tlast on 5th, no pop once remaining=0 even with the FIFO non-empty.
- Len=1 then len=2 back-to-back, FIFO C0..C2 -> C0 with tlast, o_done, then C1, C2 with tlast on C2. Len=0 cmd -> accepted, no beats, no o_done.
- Reset asserted after 2 of 6 beats -> next cycle tvalid=0, o_busy=0, o_cmd_ready=1, o_done=0, no TLAST emitted.
- Len=2^LEN_W-1 (65535), continuous data, tready=1 -> 65535 beats, tlast only on the final beat, remaining ends at 0 without wrap.
